// File: rtl/stack_pointer_unit.sv
// ---------------------------------------------------------------------------
// stack_pointer_unit
//
// Owns the architectural stack pointer and sequences one- and two-word stack
// accesses (PUSH/POP/CALL/RET/INT) in the memory stage. Drives the stack
// adder controls, the data-memory address/enables for the current word, and
// keeps sticky overflow/underflow flags.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst        synchronous, active-high reset
//   i_en         pipeline advance; 0 freezes all state
//   i_req_valid  stack request present (sampled only in IDLE)
//   i_req_push   1 = push, 0 = pop
//   i_req_two    1 = two-word access, 0 = one word
//   i_clr_err    clears sticky error flags
//   o_sp_out     current SP register
//   o_stack_op   word transfer occurs this cycle
//   o_push_pop   1 = push (SP-1), 0 = pop (SP+1)
//   o_addr_out   memory address of current word
//   o_mem_we     write current word
//   o_mem_re     read current word
//   o_word_sel   half being transferred (0 = high, 1 = low)
//   o_busy       second word in progress; upstream must hold
//   o_done       request completes this cycle
//   o_err        request completing this cycle was aborted
//   o_overflow   sticky: push attempted on full stack
//   o_underflow  sticky: pop attempted on empty stack
//
// state  | meaning
// IDLE   | waiting for a request; first (or only) word transfers here
// SECOND | second word of a two-word access transfers here
// ---------------------------------------------------------------------------
module stack_pointer_unit #(
    parameter int                   DATA_W   = 32,
    parameter logic [DATA_W-1:0]    SP_RESET = 32'h000F_FFFF,
    parameter int                   DEPTH    = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_req_valid,
    input  logic              i_req_push,
    input  logic              i_req_two,
    input  logic              i_clr_err,
    output logic [DATA_W-1:0] o_sp_out,
    output logic              o_stack_op,
    output logic              o_push_pop,
    output logic [DATA_W-1:0] o_addr_out,
    output logic              o_mem_we,
    output logic              o_mem_re,
    output logic              o_word_sel,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(DEPTH);

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_sp;
    logic               r_push;
    logic               r_ovf;
    logic               r_udf;

    logic               w_attempt;
    logic               w_is_push;
    logic               w_full;
    logic               w_empty;
    logic               w_ovf_now;
    logic               w_udf_now;
    logic               w_xfer;

    // A word is attempted when the pipeline advances and either a fresh
    // request is accepted in IDLE or the second word is pending.
    assign w_attempt = !i_rst && i_en &&
                       ((r_state == IDLE && i_req_valid) || r_state == SECOND);
    // The second word follows the direction captured at accept time.
    assign w_is_push = (r_state == SECOND) ? r_push : i_req_push;
    assign w_full    = ((SP_RESET - r_sp) == DEPTH_W);
    assign w_empty   = (r_sp == SP_RESET);
    assign w_ovf_now = w_attempt &&  w_is_push && w_full;
    assign w_udf_now = w_attempt && !w_is_push && w_empty;
    assign w_xfer    = w_attempt && !w_ovf_now && !w_udf_now;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else if (i_en) begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an aborted first word never enters SECOND.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_xfer && i_req_two) begin
                    w_state_nxt = SECOND;
                end
            end
            SECOND: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        o_stack_op = 1'b0;
        o_push_pop = 1'b0;
        o_addr_out = '0;
        o_mem_we   = 1'b0;
        o_mem_re   = 1'b0;
        o_word_sel = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        o_err      = 1'b0;
        if (!i_rst) begin
            o_busy = (r_state == SECOND);
            if (w_attempt) begin
                o_stack_op = w_xfer;
                o_push_pop = w_is_push;
                // Push is post-decrement (write at SP), pop is pre-increment.
                o_addr_out = w_is_push ? r_sp : (r_sp + 1'b1);
                o_mem_we   = w_xfer &&  w_is_push;
                o_mem_re   = w_xfer && !w_is_push;
                o_err      = w_ovf_now || w_udf_now;
                if (r_state == IDLE) begin
                    // LIFO: a push writes the high half first, a pop reads
                    // the low half first; single words are always low.
                    o_word_sel = !i_req_two || !i_req_push;
                    o_done     = !i_req_two || o_err;
                end else begin
                    o_word_sel = r_push;
                    o_done     = 1'b1;
                end
            end
        end
    end

    // SP, captured direction and sticky flags
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sp   <= SP_RESET;
            r_push <= 1'b0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
        end else if (i_en) begin
            if (w_xfer) begin
                r_sp <= w_is_push ? (r_sp - 1'b1) : (r_sp + 1'b1);
            end
            if (r_state == IDLE && i_req_valid) begin
                r_push <= i_req_push;
            end
            // Set wins over a simultaneous clear.
            if (w_ovf_now) begin
                r_ovf <= 1'b1;
            end else if (i_clr_err) begin
                r_ovf <= 1'b0;
            end
            if (w_udf_now) begin
                r_udf <= 1'b1;
            end else if (i_clr_err) begin
                r_udf <= 1'b0;
            end
        end
    end

    assign o_sp_out    = r_sp;
    assign o_overflow  = r_ovf;
    assign o_underflow = r_udf;

endmodule

// File: tb/tb_stack_pointer_unit.sv
module tb_stack_pointer_unit;

    localparam int          DATA_W   = 32;
    localparam logic [31:0] SP_RESET = 32'h000F_FFFF;
    localparam int          DEPTH    = 4;

    logic              clk;
    logic              rst;
    logic              en;
    logic              req_valid;
    logic              req_push;
    logic              req_two;
    logic              clr_err;
    logic [DATA_W-1:0] sp_out;
    logic              stack_op;
    logic              push_pop;
    logic [DATA_W-1:0] addr_out;
    logic              mem_we;
    logic              mem_re;
    logic              word_sel;
    logic              busy;
    logic              done;
    logic              err;
    logic              overflow;
    logic              underflow;

    stack_pointer_unit #(
        .DATA_W   (DATA_W),
        .SP_RESET (SP_RESET),
        .DEPTH    (DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_req_valid (req_valid),
        .i_req_push  (req_push),
        .i_req_two   (req_two),
        .i_clr_err   (clr_err),
        .o_sp_out    (sp_out),
        .o_stack_op  (stack_op),
        .o_push_pop  (push_pop),
        .o_addr_out  (addr_out),
        .o_mem_we    (mem_we),
        .o_mem_re    (mem_re),
        .o_word_sel  (word_sel),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err),
        .o_overflow  (overflow),
        .o_underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inp = {rst, en, req_valid, req_push, req_two, clr_err}
    // fl  = {stack_op, push_pop, mem_we, mem_re, word_sel, busy, done, err, overflow, underflow}
    typedef struct {
        logic [5:0]  inp;
        logic [31:0] sp;
        logic [31:0] addr;
        logic [9:0]  fl;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic [5:0] inp, input logic [31:0] sp,
                                input logic [31:0] addr, input logic [9:0] fl);
        vec_t v;
        v.inp  = inp;
        v.sp   = sp;
        v.addr = addr;
        v.fl   = fl;
        return v;
    endfunction

    // Drive one cycle's inputs, compare outputs mid-cycle, then advance.
    task automatic apply(input vec_t v, input string name);
        logic [9:0] act_fl;
        {rst, en, req_valid, req_push, req_two, clr_err} = v.inp;
        @(negedge clk);
        act_fl = {stack_op, push_pop, mem_we, mem_re, word_sel,
                  busy, done, err, overflow, underflow};
        n_cmp++;
        if (sp_out !== v.sp || addr_out !== v.addr || act_fl !== v.fl) begin
            n_bad++;
            $display("FAIL %s: got sp=%h addr=%h flags=%b, want sp=%h addr=%h flags=%b",
                     name, sp_out, addr_out, act_fl, v.sp, v.addr, v.fl);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset / idle
        vecs.push_back(mk(6'b111100, 32'hFFFFF, 32'h0, 10'b0000000000));
        vecs.push_back(mk(6'b010000, 32'hFFFFF, 32'h0, 10'b0000000000));
        vecs.push_back(mk(6'b010000, 32'hFFFFF, 32'h0, 10'b0000000000));
        // single push, single pop
        vecs.push_back(mk(6'b011100, 32'hFFFFF, 32'hFFFFF, 10'b1110101000));
        vecs.push_back(mk(6'b011000, 32'hFFFFE, 32'hFFFFF, 10'b1001101000));
        // two-word push, two-word pop
        vecs.push_back(mk(6'b011110, 32'hFFFFF, 32'hFFFFF, 10'b1110000000));
        vecs.push_back(mk(6'b010000, 32'hFFFFE, 32'hFFFFE, 10'b1110111000));
        vecs.push_back(mk(6'b011010, 32'hFFFFD, 32'hFFFFE, 10'b1001100000));
        vecs.push_back(mk(6'b010000, 32'hFFFFE, 32'hFFFFF, 10'b1001011000));
        // two-word push with en=0 stall; pop request in SECOND ignored
        vecs.push_back(mk(6'b011110, 32'hFFFFF, 32'hFFFFF, 10'b1110000000));
        vecs.push_back(mk(6'b001010, 32'hFFFFE, 32'h0,     10'b0000010000));
        vecs.push_back(mk(6'b011010, 32'hFFFFE, 32'hFFFFE, 10'b1110111000));
        vecs.push_back(mk(6'b011010, 32'hFFFFD, 32'hFFFFE, 10'b1001100000));
        vecs.push_back(mk(6'b010000, 32'hFFFFE, 32'hFFFFF, 10'b1001011000));
        // fill the stack
        vecs.push_back(mk(6'b011100, 32'hFFFFF, 32'hFFFFF, 10'b1110101000));
        vecs.push_back(mk(6'b011100, 32'hFFFFE, 32'hFFFFE, 10'b1110101000));
        vecs.push_back(mk(6'b011100, 32'hFFFFD, 32'hFFFFD, 10'b1110101000));
        vecs.push_back(mk(6'b011100, 32'hFFFFC, 32'hFFFFC, 10'b1110101000));
        // two-word push on full stack aborts on first word
        vecs.push_back(mk(6'b011110, 32'hFFFFB, 32'hFFFFB, 10'b0100001100));
        vecs.push_back(mk(6'b010000, 32'hFFFFB, 32'h0,     10'b0000000010));
        // drain
        vecs.push_back(mk(6'b011000, 32'hFFFFB, 32'hFFFFC, 10'b1001101010));
        vecs.push_back(mk(6'b011000, 32'hFFFFC, 32'hFFFFD, 10'b1001101010));
        vecs.push_back(mk(6'b011000, 32'hFFFFD, 32'hFFFFE, 10'b1001101010));
        vecs.push_back(mk(6'b011000, 32'hFFFFE, 32'hFFFFF, 10'b1001101010));
        // pop on empty
        vecs.push_back(mk(6'b011000, 32'hFFFFF, 32'h100000, 10'b0000101110));
        vecs.push_back(mk(6'b010000, 32'hFFFFF, 32'h0,      10'b0000000011));
        // clear
        vecs.push_back(mk(6'b010001, 32'hFFFFF, 32'h0,      10'b0000000011));
        vecs.push_back(mk(6'b010000, 32'hFFFFF, 32'h0,      10'b0000000000));
        // clear and underflow in the same cycle: set wins
        vecs.push_back(mk(6'b011001, 32'hFFFFF, 32'h100000, 10'b0000101100));
        vecs.push_back(mk(6'b010000, 32'hFFFFF, 32'h0,      10'b0000000001));
        vecs.push_back(mk(6'b010001, 32'hFFFFF, 32'h0,      10'b0000000001));
        vecs.push_back(mk(6'b010000, 32'hFFFFF, 32'h0,      10'b0000000000));

        {rst, en, req_valid, req_push, req_two, clr_err} = 6'b110000;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // reset while the second word of a push is pending
        apply(mk(6'b011110, 32'hFFFFF, 32'hFFFFF, 10'b1110000000), "rst_sec_first");
        apply(mk(6'b110000, 32'hFFFFE, 32'h0,     10'b0000000000), "rst_sec_abort");
        apply(mk(6'b010000, 32'hFFFFF, 32'h0,     10'b0000000000), "rst_sec_after");
        apply(mk(6'b011100, 32'hFFFFF, 32'hFFFFF, 10'b1110101000), "rst_sec_idle");
        apply(mk(6'b010000, 32'hFFFFE, 32'h0,     10'b0000000000), "rst_sec_sp");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
